// File: rtl/uart_tx.sv
// UART transmitter: one-entry holding register feeding an 8N1 serialiser.
// Define UART_TX_PARITY_EN to build the 8E1 variant with an even-parity bit.
module uart_tx #(
    parameter int CLKS_PER_BIT = 868
) (
    input  logic       CLK,
    input  logic       RST,
    input  logic [8:0] wr_arg,
    output logic       wr_out,
    output logic       tx,
    output logic       busy
);

    localparam int BAUD_W = $clog2(CLKS_PER_BIT);
    localparam logic [BAUD_W-1:0] BAUD_MAX = BAUD_W'(CLKS_PER_BIT - 1);

    typedef enum logic [2:0] {
        IDLE,
        START,
        DATA,
`ifdef UART_TX_PARITY_EN
        PARITY,
`endif
        STOP
    } state_e;

    state_e            state_q, state_d;
    logic [7:0]        shift_q, shift_d;
    logic [2:0]        bit_idx_q, bit_idx_d;
    logic [BAUD_W-1:0] baud_q, baud_d;
    logic              hold_valid_q, hold_valid_d;
    logic [7:0]        hold_data_q, hold_data_d;
    logic              tx_q, tx_d;
`ifdef UART_TX_PARITY_EN
    logic              parity_q, parity_d;
`endif

    logic       wr_valid;
    logic [7:0] wr_data;
    logic       baud_end;
    logic       load;

    assign wr_valid = wr_arg[8];
    assign wr_data  = wr_arg[7:0];
    assign baud_end = (baud_q == BAUD_MAX);

    assign wr_out = !hold_valid_q;
    assign tx     = tx_q;
    assign busy   = hold_valid_q || (state_q != IDLE);

    always_comb begin
        state_d      = state_q;
        shift_d      = shift_q;
        bit_idx_d    = bit_idx_q;
        baud_d       = baud_q;
        hold_valid_d = hold_valid_q;
        hold_data_d  = hold_data_q;
`ifdef UART_TX_PARITY_EN
        parity_d     = parity_q;
`endif
        load         = 1'b0;
        tx_d         = 1'b1;

        if (state_q != IDLE) begin
            baud_d = baud_end ? '0 : baud_q + 1'b1;
        end

        case (state_q)
            IDLE: begin
                if (hold_valid_q) load = 1'b1;
            end
            START: begin
                if (baud_end) begin
                    state_d   = DATA;
                    bit_idx_d = '0;
                end
            end
            DATA: begin
                if (baud_end) begin
                    shift_d   = {1'b0, shift_q[7:1]};
                    bit_idx_d = bit_idx_q + 1'b1;
                    if (bit_idx_q == 3'd7) begin
`ifdef UART_TX_PARITY_EN
                        state_d = PARITY;
`else
                        state_d = STOP;
`endif
                    end
                end
            end
`ifdef UART_TX_PARITY_EN
            PARITY: begin
                if (baud_end) state_d = STOP;
            end
`endif
            STOP: begin
                // A byte already held starts straight away, giving gapless frames.
                if (baud_end) begin
                    if (hold_valid_q) load = 1'b1;
                    else              state_d = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase

        if (load) begin
            state_d      = START;
            shift_d      = hold_data_q;
            hold_valid_d = 1'b0;
            baud_d       = '0;
`ifdef UART_TX_PARITY_EN
            parity_d     = ^hold_data_q;
`endif
        end

        // Accept and load are exclusive: load needs hold_valid, accept needs it clear.
        if (wr_valid && wr_out) begin
            hold_valid_d = 1'b1;
            hold_data_d  = wr_data;
        end

        // NOTE: tx is registered, so it is derived from the next state to avoid a cycle of lag.
        case (state_d)
            IDLE:    tx_d = 1'b1;
            START:   tx_d = 1'b0;
            DATA:    tx_d = shift_d[0];
`ifdef UART_TX_PARITY_EN
            PARITY:  tx_d = parity_d;
`endif
            STOP:    tx_d = 1'b1;
            default: tx_d = 1'b1;
        endcase
    end

    always_ff @(posedge CLK) begin
        if (RST) begin
            state_q      <= IDLE;
            shift_q      <= '0;
            bit_idx_q    <= '0;
            baud_q       <= '0;
            hold_valid_q <= 1'b0;
            hold_data_q  <= '0;
            tx_q         <= 1'b1;
`ifdef UART_TX_PARITY_EN
            parity_q     <= 1'b0;
`endif
        end else begin
            state_q      <= state_d;
            shift_q      <= shift_d;
            bit_idx_q    <= bit_idx_d;
            baud_q       <= baud_d;
            hold_valid_q <= hold_valid_d;
            hold_data_q  <= hold_data_d;
            tx_q         <= tx_d;
`ifdef UART_TX_PARITY_EN
            parity_q     <= parity_d;
`endif
        end
    end

endmodule

// File: tb/tb_uart_tx.sv
// Directed bench for uart_tx at CLKS_PER_BIT=4; follows UART_TX_PARITY_EN when defined.
module tb_uart_tx;

    localparam int CPB = 4;
`ifdef UART_TX_PARITY_EN
    localparam int NBITS = 11;
`else
    localparam int NBITS = 10;
`endif
    localparam int FRAME = NBITS * CPB;

    logic       CLK = 1'b0;
    logic       RST = 1'b1;
    logic       valid = 1'b0;
    logic [7:0] data = 8'h00;
    logic       wr_out, tx, busy;

    int vectors = 0;
    int miscompares = 0;
    int cyc = 0;

    always #5 CLK = ~CLK;

    uart_tx #(.CLKS_PER_BIT(CPB)) dut (
        .CLK    (CLK),
        .RST    (RST),
        .wr_arg ({valid, data}),
        .wr_out (wr_out),
        .tx     (tx),
        .busy   (busy)
    );

    task automatic step();
        @(posedge CLK);
        #1;
        cyc++;
    endtask

    task automatic chk(input string tag, input logic obs, input logic exp);
        vectors++;
        assert (obs === exp) else begin
            miscompares++;
            $error("FAIL %s: observed %b expected %b (cycle %0d)", tag, obs, exp, cyc);
        end
    endtask

    task automatic chk_idle(input string tag);
        chk({tag, " tx"}, tx, 1'b1);
        chk({tag, " ready"}, wr_out, 1'b1);
        chk({tag, " busy"}, busy, 1'b0);
    endtask

    // Checks frame cycles [skip, ncyc) of byte b; caller sits on frame cycle 'skip'.
    task automatic expect_frame(input logic [7:0] b, input int skip, input logic exp_rdy,
                                input int ncyc, input string tag);
        logic [10:0] bits;
`ifdef UART_TX_PARITY_EN
        bits = {1'b1, ^b, b, 1'b0};
`else
        bits = {1'b0, 1'b1, b, 1'b0};
`endif
        for (int off = skip; off < ncyc; off++) begin
            chk({tag, " tx"}, tx, bits[off / CPB]);
            chk({tag, " busy"}, busy, 1'b1);
            chk({tag, " ready"}, wr_out, exp_rdy);
            step();
        end
    endtask

    // One byte from idle; optionally offers 0xFF while ready is low.
    task automatic send_single(input logic [7:0] a, input logic offer_ff, input string tag);
        chk({tag, " ready c0"}, wr_out, 1'b1);
        valid = 1'b1;
        data  = a;
        step();
        chk({tag, " ready c1"}, wr_out, 1'b0);
        chk({tag, " busy c1"}, busy, 1'b1);
        chk({tag, " tx c1"}, tx, 1'b1);
        if (offer_ff) data = 8'hFF;
        else          valid = 1'b0;
        step();
        valid = 1'b0;
        expect_frame(a, 0, 1'b1, FRAME, tag);
        chk_idle({tag, " end"});
    endtask

    // Producer holds valid high: a, then b as soon as ready returns.
    task automatic send_pair(input logic [7:0] a, input logic [7:0] b, input string tag);
        chk({tag, " ready c0"}, wr_out, 1'b1);
        valid = 1'b1;
        data  = a;
        step();
        chk({tag, " ready c1"}, wr_out, 1'b0);
        data = b;
        step();
        chk({tag, " start a"}, tx, 1'b0);
        chk({tag, " ready c2"}, wr_out, 1'b1);
        step();
        valid = 1'b0;
        expect_frame(a, 1, 1'b0, FRAME, {tag, " a"});
        expect_frame(b, 0, 1'b1, FRAME, {tag, " b"});
        chk_idle({tag, " end"});
    endtask

    initial begin
        step();
        step();
        chk_idle("reset");
        RST = 1'b0;

        for (int i = 0; i < 100; i++) begin
            chk_idle("reset idle");
            step();
        end

        send_single(8'h55, 1'b0, "single 55");
        send_pair(8'hA3, 8'h0F, "backpressure");
        send_single(8'h3C, 1'b1, "ignored ff");

        // 0x81 in flight with 0x7E held; reset lands during data bit 3.
        valid = 1'b1;
        data  = 8'h81;
        step();
        valid = 1'b0;
        step();
        chk("midrst start", tx, 1'b0);
        valid = 1'b1;
        data  = 8'h7E;
        step();
        valid = 1'b0;
        expect_frame(8'h81, 1, 1'b0, 4 * CPB + 2, "midrst 81");
        RST = 1'b1;
        step();
        RST = 1'b0;
        chk_idle("midrst after");
        for (int i = 0; i < FRAME + 8; i++) begin
            chk("midrst no 7e tx", tx, 1'b1);
            chk("midrst no 7e busy", busy, 1'b0);
            step();
        end

        send_pair(8'h07, 8'h03, "parity pair");

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule

// File: doc/uart_tx.md
# uart_tx

Serial UART transmitter that terminates the core's UART write interface (`{valid, data}` request, single-bit `ready` response) and drives a physical TX line. It sits in the top-level wrapper, replacing the tie-off that keeps `ready` permanently high. Bytes are accepted into a one-entry holding register and serialised as 8N1 frames, or 8E1 with parity. The holding register gives the core real backpressure and lets consecutive frames go out back-to-back.

## Interface
- `CLKS_PER_BIT`, default 868: clock cycles per serial bit (100 MHz / 115200). Legal range is ≥2.
- `CLK`  in  1  system clock; all logic on the rising edge.
- `RST`  in  1  synchronous, active-high reset.
- `wr_arg`  in  9  `{valid, data[7:0]}`, matching the core's UART write argument.
- `wr_out`  out  1  ready; a transfer occurs in any cycle where `valid && ready`.
- `tx`  out  1  serial line, idle high, registered.
- `busy`  out  1  high while the holding register is full or a frame is in flight.

## Operation
- **Holding register.** Contains `hold_valid` and `hold_data[7:0]`.
  - `ready = !hold_valid`, derived from registers only and never from `valid`.
  - On a transfer: `hold_data <= data`, `hold_valid <= 1`.
  - When `valid` is high and `ready` is low, the request is ignored and no state changes. The producer retries.
- **FSM states.** `IDLE`, `START`, `DATA`, `PARITY` (only when the parity macro is defined), `STOP`.
  - `IDLE`: `tx=1`. If `hold_valid`: load `shift <= hold_data`, clear `hold_valid`, clear the baud counter, go to `START`.
  - `START`: `tx=0` for `CLKS_PER_BIT` cycles, then go to `DATA` with `bit_idx=0`.
  - `DATA`: `tx=shift[0]` for `CLKS_PER_BIT` cycles, then shift right and increment `bit_idx`. After bit 7, go to `PARITY` or `STOP`. Bits are sent LSB first.
  - `PARITY`: `tx = ^data` (even parity) for `CLKS_PER_BIT` cycles, then go to `STOP`.
  - `STOP`: `tx=1` for `CLKS_PER_BIT` cycles. In the final stop cycle:
    - If `hold_valid`, load directly and go to `START`, so there is no idle gap between frames.
    - Otherwise go to `IDLE`.
- **Baud counter.** Width is `$clog2(CLKS_PER_BIT)`. It counts 0..`CLKS_PER_BIT`-1 and wraps to 0 on each bit boundary.
- **busy.** `busy = hold_valid || state != IDLE`.
- **Reset values.** Whenever `RST` is sampled high, including mid-frame, all of the following apply from the next cycle:
  - `tx=1`, `wr_out=1`, `busy=0`.
  - State is `IDLE`, `hold_valid=0`, and all counters are 0.
  - Any partial frame is abandoned, and any held byte is dropped.
- **Simultaneous events.** An accept in the same cycle that `STOP` or `IDLE` drains the holding register cannot occur, because `ready=0` while `hold_valid=1`. No bypass path exists.

## Timing
- **Accept to start bit.** A byte accepted in cycle k (from an empty `IDLE` state) has `hold_valid=1` in cycle k+1 and the start bit on `tx` from cycle k+2.
- **Ready recovery.**
  - From `IDLE`, `ready` is low only in cycle k+1 and high again in cycle k+2.
  - While a frame is in flight, a second accepted byte keeps `ready` low until the cycle after it is loaded, which is one cycle after the last stop cycle.
- **Frame length.** 10×`CLKS_PER_BIT` cycles, or 11×`CLKS_PER_BIT` with parity.
- **Throughput.** Continuous streaming reaches exactly one frame per frame length.

## Configuration
- **`UART_TX_PARITY_EN`**
  - **Defined:** the `PARITY` state is present and frames are 8E1 (11 bits).
  - **Undefined:** the `PARITY` state and its logic are absent and frames are 8N1 (10 bits).
  - Port list and parameters are identical in both builds.

## Test plan
All scenarios use `CLKS_PER_BIT=4` and no parity unless stated.
- **Single byte.** Hold reset for 2 cycles, then accept 0x55 in cycle 0.
  - `tx=0` in cycles 2–5.
  - Data bits 1,0,1,0,1,0,1,0 follow, each 4 cycles, over cycles 6–37.
  - `tx=1` in cycles 38–41.
  - `busy` is high in cycles 1–41 and low in cycle 42.
  - `ready` is low only in cycle 1.
- **Backpressure.** Hold `valid` high with 0xA3, then 0x0F.
  - 0x0F is accepted in the first cycle `ready` is high after 0xA3 is loaded.
  - The start bit of 0x0F immediately follows the last stop cycle of 0xA3.
  - 0x0F is never sampled while `ready=0`.
- **Ignored request.** Assert `valid` with 0xFF while `ready=0`, then deassert it.
  - The 0xFF byte is never transmitted.
  - The frame in flight is unaltered.
- **Reset mid-frame.** Pulse `RST` for 1 cycle during data bit 3 of 0x81, with 0x7E held.
  - `tx=1`, `ready=1` and `busy=0` on the next cycle.
  - 0x7E is never transmitted.
- **Parity build.** With `UART_TX_PARITY_EN` defined, send 0x07, then 0x03.
  - The parity bit is 1 for 0x07 and 0 for 0x03.
  - Each frame is 44 cycles.
- **Reset idle.** Drive `valid=0` continuously after reset.
  - `tx` stays 1, `ready` stays 1, and `busy` stays 0 for 100 cycles.
